dec_count_ctrl: RTL
===================

DEC_COUNT_CTRL -- requirements
Module: dec_count_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: clear  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  begin a run from IDLE, or resume from HOLD.
REQ-004 SHALL have ports: stop  in  1  pause a run (RUN -> HOLD).
REQ-005 SHALL have ports: abort  in  1  cancel a run, return to IDLE.
REQ-006 SHALL have ports: mode  in  1  0 = one-shot, 1 = auto-reload.
REQ-007 SHALL have ports: target  in  8  two-digit BCD terminal count {tens, units}, sampled on accepted start.
REQ-008 SHALL have ports: cnt_q  in  4  current value of the controlled decade counter.
REQ-009 SHALL have ports: cnt_en  out  1  counter advances (9 wraps to 0) on the next edge when high.
REQ-010 SHALL have ports: cnt_clr  out  1  counter clears to 0 on the next edge when high; overrides cnt_en.
REQ-011 SHALL have ports: tens  out  4  tens digit kept by the controller.
REQ-012 SHALL have ports: busy  out  1  high in LOAD, RUN and HOLD.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse at terminal count.
REQ-014 SHALL have ports: err  out  1  sticky error flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, HOLD and DONE; all outputs Moore except cnt_en.
REQ-016 IDLE: start with valid BCD target (both nibbles <= 9) SHALL latch target, clear err, and go to LOAD.
REQ-017 IDLE: start with an invalid BCD target SHALL set err, stay in IDLE, and not assert cnt_clr.
REQ-018 LOAD SHALL assert cnt_clr for exactly one cycle, clear tens to 0, and go to RUN.
REQ-019 RUN: cnt_en SHALL equal (state==RUN) AND NOT match AND NOT stop AND NOT abort, where match = ({tens,cnt_q} == latched target).
REQ-020 RUN: match SHALL go to DONE; match has priority over stop.
REQ-021 RUN: stop without match SHALL go to HOLD with counter value frozen.
REQ-022 HOLD: cnt_en SHALL be 0; start SHALL go to RUN; otherwise remain in HOLD.
REQ-023 abort in LOAD, RUN or HOLD SHALL go to IDLE on the next edge, clear tens, and produce no done.
REQ-024 Input priority SHALL be abort > match > stop > start.
REQ-025 DONE SHALL assert done for one cycle, then go to LOAD if mode=1 (reusing the latched target, no resample) or to IDLE if mode=0.
REQ-026 tens SHALL increment modulo 10 on an edge where cnt_en=1 and cnt_q=9, and hold otherwise (except for clears per REQ-018/023).
REQ-027 cnt_q > 9 observed in RUN SHALL set err and go to IDLE with cnt_en=0 in that cycle.
REQ-028 Latency SHALL be: start sampled at edge k -> LOAD after k -> RUN after k+1 -> for target value N (0..99) the state enters DONE at edge k+N+2, so done is high in the cycle following edge k+N+2.
REQ-029 Target 00 SHALL match in the first RUN cycle with zero cnt_en cycles.
REQ-030 start in RUN, LOAD or DONE SHALL be ignored; stop outside RUN SHALL be ignored.

Reset
REQ-031 clear=0 SHALL immediately force IDLE, with cnt_en=0, cnt_clr=0, tens=0, busy=0, done=0, err=0 and the latched target = 8'h00, independent of clock.
REQ-032 Release of clear SHALL take effect synchronously; the first transition is possible on the first rising edge after clear=1.

Verification (bench includes a behavioural decade counter driven by cnt_en and cnt_clr)
REQ-033 Verification SHALL cover the following scenario: clear=0 pulsed mid-RUN with tens=1 -> all outputs 0 within the same timestep, IDLE, no done.
REQ-034 Verification SHALL cover the following scenario: mode=0, target=8'h23, start at edge k -> cnt_clr high one cycle, tens steps 0->1->2 at the 9->0 wraps, 23 cnt_en cycles, done single pulse after edge k+25, then busy=0.
REQ-035 Verification SHALL cover the following scenario: target=8'h05, stop for 3 cycles while cnt_q=2 -> cnt_q holds 2, busy=1; start resumes; done arrives exactly 4 cycles later than unpaused (3 stop cycles + 1 start cycle in HOLD).
REQ-036 Verification SHALL cover the following scenario: target=8'h1A with start -> err=1, state stays IDLE, cnt_clr never asserted; a following valid start clears err.
REQ-037 Verification SHALL cover the following scenario: mode=1, target=8'h03 -> done pulses periodically every 6 cycles (LOAD + 4 RUN + DONE) until mode=0, then one final done and IDLE.
REQ-038 Verification SHALL cover the following scenario: abort in HOLD, and abort coincident with match -> IDLE on the next edge, tens=0, no done pulse.

Source files
------------

// File: rtl/dec_count_ctrl.sv
// Run controller for an external decade counter: counts {tens, cnt_q} up to a
// latched two-digit BCD target, with pause/resume, abort and optional auto-reload.
module dec_count_ctrl (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       abort,
  input  logic       mode,
  input  logic [7:0] target,
  input  logic [3:0] cnt_q,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] tens,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] target_q, target_d;
  logic [3:0] tens_q, tens_d;
  logic       err_q, err_d;
  logic       cnt_clr_q, busy_q, done_q;
  logic       match_s, cnt_bad_s, run_s;

  function automatic logic is_bcd_pair(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign run_s     = (state_q == S_RUN);
  assign match_s   = ({tens_q, cnt_q} == target_q);
  assign cnt_bad_s = (cnt_q > 4'd9);

  // A corrupt counter value must not advance the counter in the cycle it is seen.
  assign cnt_en  = run_s & ~match_s & ~stop & ~abort & ~cnt_bad_s;
  assign cnt_clr = cnt_clr_q;
  assign tens    = tens_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

  // Next-state, target latch, tens digit and error flag.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    tens_d   = tens_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          if (is_bcd_pair(target)) begin
            target_d = target;
            err_d    = 1'b0;
            state_d  = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tens_d = 4'd0;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          tens_d  = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_bad_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (match_s) begin
          state_d = S_DONE;
        end else if (stop) begin
          state_d = S_HOLD;
        end else if (cnt_q == 4'd9) begin
          tens_d = bcd_inc(tens_q);
        end else begin
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        if (abort) begin
          tens_d  = 4'd0;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        if (abort) begin
          tens_d  = 4'd0;
          state_d = S_IDLE;
        end else if (mode) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        tens_d  = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; Moore outputs are registered from the next state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      target_q  <= 8'h00;
      tens_q    <= 4'd0;
      err_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      tens_q    <= tens_d;
      err_q     <= err_d;
      cnt_clr_q <= (state_d == S_LOAD);
      busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_HOLD);
      done_q    <= (state_d == S_DONE);
    end
  end

endmodule
